shift_unit: RTL

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/shift_unit.sv
// Multi-cycle shifter: shifts an 8-bit operand one bit per cycle (left, logical
// right or arithmetic right) and writes the result and flags back in a single WB cycle.
module shift_unit #(
   parameter int pw = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          dir,
   input  logic          arith,
   input  logic [7:0]    datA_in,
   input  logic [7:0]    datB_in,
   input  logic [pw-1:0] dst_addr,
   output logic          busy,
   output logic          done,
   output logic          wr_en,
   output logic [pw-1:0] wr_addr,
   output logic [7:0]    dat_out,
   output logic          zeroOut,
   output logic          ngtvOut,
   output logic          scryOut
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WB    = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [7:0]    result;
   logic [3:0]    count;
   logic          dir_q;
   logic          arith_q;
   logic [pw-1:0] addr_q;
   logic          scry_q;

   // Only the low nibble of the amount operand is meaningful.
   logic          unused_amount_hi;
   assign unused_amount_hi = ^datB_in[7:4];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (datB_in[3:0] != 4'd0) ? SHIFT : WB;
         SHIFT:   if (count == 4'd1) state_nx = WB;
         WB:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      done  = (state == WB);
      wr_en = (state == WB);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result  <= '0;
         count   <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
         addr_q  <= '0;
         scry_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  result  <= datA_in;
                  count   <= datB_in[3:0];
                  dir_q   <= dir;
                  arith_q <= arith;
                  addr_q  <= dst_addr;
                  scry_q  <= 1'b0;
               end
            end
            SHIFT: begin
               count <= count - 4'd1;
               if (!dir_q) begin
                  scry_q <= result[7];
                  result <= {result[6:0], 1'b0};
               end else begin
                  scry_q <= result[0];
                  result <= {arith_q & result[7], result[7:1]};
               end
            end
            default: ;
         endcase
      end
   end

   assign dat_out = result;
   assign wr_addr = addr_q;
   assign zeroOut = (result == 8'h00);
   assign ngtvOut = result[7];
   assign scryOut = scry_q;

endmodule
